// File: rtl/pico_pkg.sv
// pico_pkg: opcode, FSM state and ALU-select types shared by the pico core.
package pico_pkg;

  typedef enum logic [2:0] {
    OP_HEI  = 3'd0,
    OP_LSW  = 3'd1,
    OP_MULI = 3'd2,
    OP_ATR  = 3'd3,
    OP_RTA  = 3'd4,
    OP_ADD  = 3'd5,
    OP_ADDI = 3'd6,
    OP_JMP  = 3'd7
  } opcode_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_ADDI = 2'd2,
    ALU_MUL  = 2'd3
  } alu_op_t;

endpackage

// File: rtl/pico_alu.sv
// pico_alu: combinational accumulator datapath (pass, ADD, ADDI, fixed-point MULI)
// with signed overflow detection. Define PICO_SAT_EN to clamp overflowing
// results to the signed DATA_W range; otherwise results wrap.
module pico_alu
  import pico_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPND_W = 5,
  parameter int FRAC_W = 2
) (
  input  alu_op_t                   alu_sel,
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [DATA_W-1:0]  b,
  input  logic        [OPND_W-1:0]  imm,
  output logic signed [DATA_W-1:0]  result,
  output logic                      overflow
);

  // Wide enough for the full product plus the shifted immediate without loss.
  localparam int WW = 2 * DATA_W + OPND_W + 2;

  logic signed [WW-1:0]       a_w;
  logic signed [WW-1:0]       b_w;
  logic signed [WW-1:0]       imm_w;
  logic signed [WW-1:0]       wide;
  logic        [WW-DATA_W:0]  top;
  logic                       fits;

  // Exact result in a wide signed domain, then range check and wrap/clamp.
  always_comb begin
    a_w   = {{(WW-DATA_W){a[DATA_W-1]}}, a};
    b_w   = {{(WW-DATA_W){b[DATA_W-1]}}, b};
    imm_w = {{(WW-OPND_W){imm[OPND_W-1]}}, imm};
    case (alu_sel)
      ALU_ADD:  wide = a_w + b_w;
      ALU_ADDI: wide = a_w + (imm_w <<< 1);
      ALU_MUL:  wide = (a_w * imm_w) >>> FRAC_W;
      default:  wide = b_w;
    endcase
    top      = wide[WW-1:DATA_W-1];
    fits     = (&top) | ~(|top);
    overflow = (alu_sel != ALU_PASS) && !fits;
`ifdef PICO_SAT_EN
    if (overflow) begin
      result = wide[WW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      result = wide[DATA_W-1:0];
    end
`else
    result = wide[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/pico_core.sv
// pico_core: two-state (FETCH/EXEC) accumulator micro-core with a small
// register file, handshake stall (HEI) and sticky overflow flag.
// Optional PICO_SAT_EN macro selects saturating arithmetic in pico_alu.
module pico_core
  import pico_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 2,
  parameter int PC_W   = 5,
  parameter int OPND_W = 5,
  parameter int FRAC_W = 2
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic signed [DATA_W-1:0] sw_data,
  input  logic                     sw_flag,
  output logic        [PC_W-1:0]   imem_addr,
  input  logic      [3+OPND_W-1:0] imem_data,
  output logic signed [DATA_W-1:0] acc_out,
  output logic                     waiting,
  output logic                     ovf
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t                    state;
  logic        [PC_W-1:0]    pc;
  logic signed [DATA_W-1:0]  acc;
  logic signed [DATA_W-1:0]  regs [NREGS];
  logic                      ovf_q;

  opcode_t                   op;
  logic        [OPND_W-1:0]  operand;
  logic        [IDX_W-1:0]   idx;
  logic signed [DATA_W-1:0]  reg_rd;
  logic        [PC_W-1:0]    jmp_pc;
  logic                      stall;
  alu_op_t                   alu_sel;
  logic signed [DATA_W-1:0]  alu_result;
  logic                      alu_ovf;

  // Decode the instruction word and read the register file combinationally.
  always_comb begin
    op      = opcode_t'(imem_data[3+OPND_W-1:OPND_W]);
    operand = imem_data[OPND_W-1:0];
    idx     = IDX_W'(operand);
    jmp_pc  = PC_W'(operand);
    reg_rd  = regs[idx];
    stall   = (state == ST_EXEC) && (op == OP_HEI) && (sw_flag == operand[0]);
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_ADDI: alu_sel = ALU_ADDI;
      OP_MULI: alu_sel = ALU_MUL;
      default: alu_sel = ALU_PASS;
    endcase
  end

  pico_alu #(
    .DATA_W (DATA_W),
    .OPND_W (OPND_W),
    .FRAC_W (FRAC_W)
  ) u_alu (
    .alu_sel  (alu_sel),
    .a        (acc),
    .b        (reg_rd),
    .imm      (operand),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  // FSM, program counter, accumulator, register file and sticky overflow.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= ST_FETCH;
      pc    <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (!stall) begin
            state <= ST_FETCH;
            pc    <= pc + PC_W'(1);
            case (op)
              OP_LSW: acc <= sw_data;
              OP_MULI, OP_ADD, OP_ADDI: begin
                acc   <= alu_result;
                ovf_q <= ovf_q | alu_ovf;
              end
              OP_ATR: regs[idx] <= acc;
              OP_RTA: acc <= reg_rd;
              OP_JMP: pc <= jmp_pc;
              default: ;
            endcase
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign imem_addr = pc;
  assign acc_out   = acc;
  assign ovf       = ovf_q;
  assign waiting   = stall;

endmodule

// File: tb/tb_pico_core.sv
// tb_pico_core: self-checking bench for pico_core. An instruction-level
// reference model tracks pc, acc, registers and ovf every cycle; directed
// phases check the documented scenarios. Honours PICO_SAT_EN like the RTL.
module tb_pico_core;
  import pico_pkg::*;

  logic              Clock;
  logic              nReset;
  logic signed [7:0] sw_data;
  logic              sw_flag;
  logic [4:0]        imem_addr;
  logic [7:0]        imem_data;
  logic signed [7:0] acc_out;
  logic              waiting;
  logic              ovf;
  logic [7:0]        rom [32];

  logic signed [11:0] sw_data2;
  logic [4:0]         imem_addr2;
  logic [7:0]         imem_data2;
  logic signed [11:0] acc_out2;
  logic               waiting2;
  logic               ovf2;
  logic [7:0]         rom2 [32];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_pc;
  int m_acc;
  int m_regs [2];
  bit m_exec;
  bit m_ovf;

  pico_core dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .sw_data   (sw_data),
    .sw_flag   (sw_flag),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .acc_out   (acc_out),
    .waiting   (waiting),
    .ovf       (ovf)
  );

  pico_core #(
    .DATA_W (12),
    .NREGS  (4)
  ) dut2 (
    .Clock     (Clock),
    .nReset    (nReset),
    .sw_data   (sw_data2),
    .sw_flag   (1'b0),
    .imem_addr (imem_addr2),
    .imem_data (imem_data2),
    .acc_out   (acc_out2),
    .waiting   (waiting2),
    .ovf       (ovf2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // synchronous program ROMs
  always @(posedge Clock) begin
    imem_data  <= rom[imem_addr];
    imem_data2 <= rom2[imem_addr2];
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input int opnd);
    logic [4:0] o;
    o = opnd[4:0];
    return {op, o};
  endfunction

  task automatic fit(input int v, output int r);
    if (v > 127 || v < -128) begin
      m_ovf = 1'b1;
`ifdef PICO_SAT_EN
      r = (v > 127) ? 127 : -128;
`else
      r = v & 255;
      if (r >= 128) r = r - 256;
`endif
    end else begin
      r = v;
    end
  endtask

  function automatic bit m_wait();
    logic [7:0] w;
    w = rom[m_pc];
    return m_exec && (w[7:5] == OP_HEI) && (sw_flag == w[0]);
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_regs[0] = 0; m_regs[1] = 0; m_exec = 0; m_ovf = 0;
  endtask

  // One clock of the reference model, using the inputs currently driven.
  task automatic model_clock();
    logic [7:0] w;
    int opnd, sop, idx, r;
    if (!m_exec) begin
      m_exec = 1'b1;
      return;
    end
    w    = rom[m_pc];
    opnd = int'(w[4:0]);
    sop  = (opnd >= 16) ? opnd - 32 : opnd;
    idx  = opnd % 2;
    case (w[7:5])
      3'd0: if (sw_flag == w[0]) return;
      3'd1: m_acc = sw_data;
      3'd2: begin r = (m_acc * sop) >>> 2; fit(r, m_acc); end
      3'd3: m_regs[idx] = m_acc;
      3'd4: m_acc = m_regs[idx];
      3'd5: fit(m_acc + m_regs[idx], m_acc);
      3'd6: fit(m_acc + sop * 2, m_acc);
      default: begin m_pc = opnd; m_exec = 1'b0; return; end
    endcase
    m_pc   = (m_pc + 1) % 32;
    m_exec = 1'b0;
  endtask

  // Compare against the model mid-cycle, advance model, step to posedge+1.
  task automatic tick();
    @(negedge Clock);
    check("addr", imem_addr, m_pc);
    check("acc",  acc_out,   m_acc);
    check("wait", waiting,   m_wait());
    check("ovf",  ovf,       m_ovf);
    model_clock();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_until(input int target, input string tag);
    int n;
    n = 0;
    while (imem_addr != target && n < 200) begin
      tick();
      n++;
    end
    check(tag, imem_addr, target);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    #1;
    check("rst_acc",  acc_out,   0);
    check("rst_addr", imem_addr, 0);
    check("rst_wait", waiting,   0);
    check("rst_ovf",  ovf,       0);
    model_reset();
    @(posedge Clock);
    #1;
    nReset = 1'b1;
  endtask

  task automatic wait2(input int target, input string tag);
    int n;
    n = 0;
    while (imem_addr2 != target && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check(tag, imem_addr2, target);
  endtask

  initial begin
    nReset   = 1'b0;
    sw_data  = '0;
    sw_flag  = 1'b0;
    sw_data2 = -12'sd1000;
    for (int i = 0; i < 32; i++) begin
      rom[i]  = ins(OP_JMP, 0);
      rom2[i] = ins(OP_JMP, 5);
    end

    // wider instance: register round trip and fixed-point multiply
    rom2[0] = ins(OP_LSW, 0);
    rom2[1] = ins(OP_ATR, 3);
    rom2[2] = ins(OP_MULI, 0);
    rom2[3] = ins(OP_RTA, 3);
    rom2[4] = ins(OP_MULI, 2);
    rom2[5] = ins(OP_JMP, 5);
    do_reset();
    wait2(3, "w_muli0");
    check("w_acc_zero", acc_out2, 0);
    wait2(4, "w_rta");
    check("w_roundtrip", acc_out2, -1000);
    wait2(5, "w_muli2");
    check("w_half", acc_out2, -500);
    check("w_ovf", ovf2, 0);

    // rotation program with handshake
    rom[0]  = ins(OP_HEI, 0);
    rom[1]  = ins(OP_LSW, 0);
    rom[2]  = ins(OP_ATR, 0);
    rom[3]  = ins(OP_HEI, 1);
    rom[4]  = ins(OP_LSW, 0);
    rom[5]  = ins(OP_ATR, 1);
    rom[6]  = ins(OP_ADD, 0);
    rom[7]  = ins(OP_ATR, 1);
    rom[8]  = ins(OP_RTA, 0);
    rom[9]  = ins(OP_MULI, -4);
    rom[10] = ins(OP_ADDI, 10);
    rom[11] = ins(OP_MULI, 5);
    rom[12] = ins(OP_HEI, 0);
    rom[13] = ins(OP_HEI, 1);
    do_reset();
    repeat (4) tick();
    check("hei0_stall", waiting, 1);
    sw_flag = 1'b1; sw_data = 8'sd40;
    run_until(3, "to_hei1");
    repeat (3) tick();
    sw_flag = 1'b0; sw_data = 8'sd20;
    run_until(7, "to_sum");
    check("rot_sum", acc_out, 60);
    run_until(12, "to_rot");
    check("rot_diff", acc_out, -25);
    check("rot_ovf", ovf, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_wait", waiting, 1);
      check("stall_pc", imem_addr, 12);
    end
    sw_flag = 1'b1;
    tick();
    check("release_wait", waiting, 0);
    check("release_pc", imem_addr, 13);
    repeat (3) tick();
    check("stall2_wait", waiting, 1);

    // reset in the middle of a stall, then confirm registers were cleared
    rom[0] = ins(OP_LSW, 0);
    rom[1] = ins(OP_RTA, 1);
    rom[2] = ins(OP_LSW, 0);
    rom[3] = ins(OP_ADDI, 15);
    rom[4] = ins(OP_JMP, 4);
    do_reset();
    sw_data = 8'sd55;
    run_until(1, "to_rta");
    run_until(2, "rta_done");
    check("reg1_cleared", acc_out, 0);
    sw_data = 8'sd100;
    run_until(4, "to_addi");
`ifdef PICO_SAT_EN
    check("addi_ovf_acc", acc_out, 127);
`else
    check("addi_ovf_acc", acc_out, -126);
`endif
    check("addi_ovf_flag", ovf, 1);
    repeat (6) tick();
    check("ovf_sticky", ovf, 1);

    // jump and pc wrap at the top of the program space
    for (int i = 0; i < 32; i++) rom[i] = ins(OP_LSW, 0);
    rom[0]  = ins(OP_JMP, 30);
    rom[3]  = ins(OP_JMP, 30);
    rom[31] = ins(OP_JMP, 3);
    do_reset();
    run_until(31, "to_31a");
    tick(); tick();
    check("jmp_from_31", imem_addr, 3);
    rom[31] = ins(OP_LSW, 0);
    run_until(31, "to_31b");
    tick(); tick();
    check("wrap_from_31", imem_addr, 0);

    // random programs against the model, with a reset partway through
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sw_flag = 1'($urandom);
      sw_data = 8'($urandom);
      if (c == 1500) begin
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
        do_reset();
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
